fetch_pc_ctrl: RTL and testbench

- Fetch-stage program-counter owner for the pipelined RV32 core: holds the PC, issues fetch requests to instruction memory, and applies EX-stage redirects (branch / JALR).
- Drives the {s1,s0} selects consumed by the 3-input next-PC select.
- Squashes wrong-path fetches and flushes IF/ID and ID/EX on redirect.
- Sits between the hazard unit / EX stage and the IF/ID pipeline register.

---
 rtl/fetch_pc_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_fetch_pc_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_pc_ctrl
//
// Fetch-stage program-counter owner for the pipelined RV32 core. Holds the
// PC, issues fetch requests to instruction memory, applies EX-stage
// redirects (branch / JAL / JALR) and squashes wrong-path work in IF/ID and
// ID/EX.
//
// Fetch handshake: imem_req is the request valid and imem_gnt is the memory
// ready. A fetch of address `pc` happens on a rising edge where both are 1.
// imem_req never drops once it rises after reset, so nothing is withdrawn.
//
// Optional feature macro: FETCH_MISALIGN_CHECK_EN
//   defined   -> adds output misalign_err, a sticky flag raised when a
//                redirect arrives with a target whose low two bits are not 00
//   undefined -> no port; misaligned targets are silently aligned
//
// Ports:
//   clk, rst_n        core clock (rising edge), async active-low reset
//   stall             hazard-unit stall, freezes sequential PC advance
//   ex_redirect       EX resolved taken branch/jump (one-cycle pulse)
//   ex_is_jalr        1 = target from ALU result, 0 = computed target
//   ex_branch_target  computed branch/JAL target
//   ex_alu_result     ALU result; JALR target is bits [PC_W-1:0]
//   imem_gnt          instruction memory accepts the request
//   imem_req          fetch request valid
//   pc, pc_plus4      current fetch address and pc+4 (mod 2^PC_W)
//   pc_sel_s1/s0      next-PC select: 00 pc+4, 01 branch target, 11 ALU
//   if_valid          instruction entering IF/ID is correct-path
//   flush_if_id/id_ex one-cycle squash of IF/ID and ID/EX after a redirect
//   redirect_cnt      saturating count of applied redirects
//   dbg_pend          debug view of the FSM: 1 = PEND, 0 = RUN
//   misalign_err      (macro only) sticky misaligned-target flag
// ---------------------------------------------------------------------------
module fetch_pc_ctrl #(
  parameter int unsigned PC_W     = 9,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              ex_redirect,
  input  logic              ex_is_jalr,
  input  logic [PC_W-1:0]   ex_branch_target,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic              imem_gnt,
  output logic              imem_req,
  output logic [PC_W-1:0]   pc,
  output logic [PC_W-1:0]   pc_plus4,
  output logic              pc_sel_s1,
  output logic              pc_sel_s0,
  output logic              if_valid,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic [CNT_W-1:0]  redirect_cnt,
  output logic              dbg_pend
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic              misalign_err
`endif
);

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_e;

  localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC & ~32'd3);
  localparam logic [PC_W-1:0] PC_STEP    = PC_W'(4);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   pend_q, pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ifv_q, ifv_d;
  logic              req_q;
  logic              flush_q;

  logic              fire;
  logic [PC_W-1:0]   raw_tgt;
  logic [PC_W-1:0]   new_tgt;
  logic [PC_W-1:0]   pc_inc;
  logic [CNT_W-1:0]  cnt_inc;
  logic [1:0]        sel;

  // Only the low PC_W bits of the ALU result form a JALR target.
  logic unused_alu_hi;
  assign unused_alu_hi = ^ex_alu_result[DATA_W-1:PC_W];

  assign fire    = req_q & imem_gnt;
  assign raw_tgt = ex_is_jalr ? ex_alu_result[PC_W-1:0] : ex_branch_target;
  // Instructions are word aligned, so the low two target bits are dropped.
  assign new_tgt = {raw_tgt[PC_W-1:2], 2'b00};
  assign pc_inc  = pc_q + PC_STEP;
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_ONE;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    ifv_d   = ifv_q;
    sel     = 2'b00;
    case (state_q)
      RUN: begin
        if (ex_redirect) begin
          // Redirect wins over stall; whatever is fetched this cycle is
          // wrong-path, so the IF/ID slot is marked invalid.
          sel   = ex_is_jalr ? 2'b11 : 2'b01;
          ifv_d = 1'b0;
          if (fire) begin
            pc_d  = new_tgt;
            cnt_d = cnt_inc;
          end else begin
            pend_d  = new_tgt;
            state_d = PEND;
          end
        end else if (!stall) begin
          ifv_d = fire;
          if (fire) begin
            pc_d = pc_inc;
          end
        end
        // Stall with no redirect: IF/ID holds, so if_valid holds too.
      end
      PEND: begin
        ifv_d = 1'b0;
        if (fire) begin
          // A redirect arriving in the same cycle as the grant is newer
          // than the stored one and is applied directly.
          pc_d    = ex_redirect ? new_tgt : pend_q;
          cnt_d   = cnt_inc;
          state_d = RUN;
        end else if (ex_redirect) begin
          pend_d = new_tgt;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC_V;
      pend_q  <= '0;
      cnt_q   <= '0;
      ifv_q   <= 1'b0;
      req_q   <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      ifv_q   <= ifv_d;
      req_q   <= 1'b1;
      flush_q <= ex_redirect;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic mis_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_q <= 1'b0;
    end else if (ex_redirect && (raw_tgt[1:0] != 2'b00)) begin
      mis_q <= 1'b1;
    end
  end

  assign misalign_err = mis_q;
`else
  logic unused_tgt_lo;
  assign unused_tgt_lo = ^raw_tgt[1:0];
`endif

  assign imem_req     = req_q;
  assign pc           = pc_q;
  assign pc_plus4     = pc_inc;
  assign pc_sel_s1    = sel[1];
  assign pc_sel_s0    = sel[0];
  assign if_valid     = ifv_q;
  assign flush_if_id  = flush_q;
  assign flush_id_ex  = flush_q;
  assign redirect_cnt = cnt_q;
  assign dbg_pend     = (state_q == PEND);

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_pc_ctrl
//
// Directed vectors for fetch_pc_ctrl. Each vector sets the inputs for one
// cycle and carries the hand-computed outputs expected during that cycle.
// The driver pushes the expected output word into exp_q; the monitor pops
// and compares it on the falling edge. A second instance with CNT_W=2 runs
// on the same inputs so redirect counter saturation is reached quickly.
// ---------------------------------------------------------------------------
module tb_fetch_pc_ctrl;

  localparam int W = 44;

  // clock / reset
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic        stall;
  logic        ex_redirect;
  logic        ex_is_jalr;
  logic [8:0]  ex_branch_target;
  logic [31:0] ex_alu_result;
  logic        imem_gnt;
  logic        imem_req;
  logic [8:0]  pc;
  logic [8:0]  pc_plus4;
  logic        pc_sel_s1;
  logic        pc_sel_s0;
  logic        if_valid;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic [15:0] redirect_cnt;
  logic        dbg_pend;
  logic        mis_act;

  // small-counter instance
  logic        unused_u2_req;
  logic [8:0]  unused_u2_pc;
  logic [8:0]  unused_u2_pc4;
  logic        unused_u2_s1;
  logic        unused_u2_s0;
  logic        unused_u2_ifv;
  logic        unused_u2_fl1;
  logic        unused_u2_fl2;
  logic [1:0]  u2_cnt;
  logic        unused_u2_pend;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_err;
  logic unused_u2_mis;
  assign mis_act = misalign_err;
`else
  assign mis_act = 1'b0;
`endif

  fetch_pc_ctrl #(
    .PC_W(9), .DATA_W(32), .RESET_PC(0), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .ex_redirect(ex_redirect),
    .ex_is_jalr(ex_is_jalr), .ex_branch_target(ex_branch_target),
    .ex_alu_result(ex_alu_result), .imem_gnt(imem_gnt),
    .imem_req(imem_req), .pc(pc), .pc_plus4(pc_plus4),
    .pc_sel_s1(pc_sel_s1), .pc_sel_s0(pc_sel_s0), .if_valid(if_valid),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .redirect_cnt(redirect_cnt), .dbg_pend(dbg_pend)
`ifdef FETCH_MISALIGN_CHECK_EN
    , .misalign_err(misalign_err)
`endif
  );

  fetch_pc_ctrl #(
    .PC_W(9), .DATA_W(32), .RESET_PC(0), .CNT_W(2)
  ) dut_c2 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .ex_redirect(ex_redirect),
    .ex_is_jalr(ex_is_jalr), .ex_branch_target(ex_branch_target),
    .ex_alu_result(ex_alu_result), .imem_gnt(imem_gnt),
    .imem_req(unused_u2_req), .pc(unused_u2_pc), .pc_plus4(unused_u2_pc4),
    .pc_sel_s1(unused_u2_s1), .pc_sel_s0(unused_u2_s0),
    .if_valid(unused_u2_ifv), .flush_if_id(unused_u2_fl1),
    .flush_id_ex(unused_u2_fl2), .redirect_cnt(u2_cnt),
    .dbg_pend(unused_u2_pend)
`ifdef FETCH_MISALIGN_CHECK_EN
    , .misalign_err(unused_u2_mis)
`endif
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int           n_vec;
  int           n_mis;
  logic         exp_mis;

  function automatic logic [W-1:0] pack(
    input logic [8:0]  f_pc,
    input logic [8:0]  f_pc4,
    input logic [1:0]  f_sel,
    input logic        f_ifv,
    input logic        f_fl_if,
    input logic        f_fl_id,
    input logic [15:0] f_cnt,
    input logic        f_req,
    input logic        f_pend,
    input logic        f_mis,
    input logic [1:0]  f_cnt2
  );
    return {f_pc, f_pc4, f_sel, f_ifv, f_fl_if, f_fl_id, f_cnt, f_req,
            f_pend, f_mis, f_cnt2};
  endfunction

  // monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = pack(pc, pc_plus4, {pc_sel_s1, pc_sel_s0}, if_valid, flush_if_id,
               flush_id_ex, redirect_cnt, imem_req, dbg_pend, mis_act,
               u2_cnt);
      n_vec++;
      if (a !== e) begin
        n_mis++;
        $display("FAIL vec%0d: got %h (pc=%h sel=%b ifv=%b fl=%b%b cnt=%0d req=%b pend=%b mis=%b cnt2=%0d) want %h",
                 n_vec, a, pc, {pc_sel_s1, pc_sel_s0}, if_valid, flush_if_id,
                 flush_id_ex, redirect_cnt, imem_req, dbg_pend, mis_act,
                 u2_cnt, e);
      end
    end
  end

  // driver tasks
  task automatic zero_inputs();
    stall            = 1'b0;
    ex_redirect      = 1'b0;
    ex_is_jalr       = 1'b0;
    ex_branch_target = '0;
    ex_alu_result    = '0;
    imem_gnt         = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n   = 1'b0;
    zero_inputs();
    exp_mis = 1'b0;
    exp_q.push_back(pack(9'h000, 9'h004, 2'b00, 1'b0, 1'b0, 1'b0, 16'd0,
                         1'b0, 1'b0, 1'b0, 2'd0));
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic cyc(
    input logic        st,
    input logic        rd,
    input logic        jr,
    input logic [8:0]  bt,
    input logic [31:0] alu,
    input logic        gn,
    input logic [8:0]  e_pc,
    input logic [1:0]  e_sel,
    input logic        e_ifv,
    input logic        e_fl,
    input logic [15:0] e_cnt,
    input logic        e_pend
  );
    logic [8:0] e_pc4;
    logic [1:0] e_cnt2;
    @(posedge clk);
    #1;
    stall            = st;
    ex_redirect      = rd;
    ex_is_jalr       = jr;
    ex_branch_target = bt;
    ex_alu_result    = alu;
    imem_gnt         = gn;
    e_pc4  = e_pc + 9'd4;
    e_cnt2 = (e_cnt > 16'd3) ? 2'd3 : e_cnt[1:0];
    exp_q.push_back(pack(e_pc, e_pc4, e_sel, e_ifv, e_fl, e_fl, e_cnt, 1'b1,
                         e_pend, exp_mis, e_cnt2));
  endtask

  // stimulus
  initial begin
    n_vec   = 0;
    n_mis   = 0;
    exp_mis = 1'b0;
    rst_n   = 1'b0;
    zero_inputs();
    do_reset();

    //   st rd jr target  alu            gn | pc     sel   ifv fl cnt pend
    // sequential fetch from reset, if_valid from the second cycle
    cyc(0, 0, 0, 9'h000, 32'h0,         1,  9'h000, 2'b00, 0, 0, 16'd0, 0);
    cyc(0, 0, 0, 9'h000, 32'h0,         1,  9'h004, 2'b00, 1, 0, 16'd0, 0);
    cyc(0, 0, 0, 9'h000, 32'h0,         1,  9'h008, 2'b00, 1, 0, 16'd0, 0);
    // five stall cycles: pc and if_valid hold, no flush
    for (int i = 0; i < 5; i++)
      cyc(1, 0, 0, 9'h000, 32'h0,       1,  9'h00C, 2'b00, 1, 0, 16'd0, 0);
    cyc(0, 0, 0, 9'h000, 32'h0,         1,  9'h00C, 2'b00, 1, 0, 16'd0, 0);
    // no grant: pc holds, if_valid drops
    cyc(0, 0, 0, 9'h000, 32'h0,         0,  9'h010, 2'b00, 1, 0, 16'd0, 0);
    cyc(0, 0, 0, 9'h000, 32'h0,         1,  9'h010, 2'b00, 0, 0, 16'd0, 0);
    cyc(0, 0, 0, 9'h000, 32'h0,         1,  9'h014, 2'b00, 1, 0, 16'd0, 0);
    cyc(0, 0, 0, 9'h000, 32'h0,         1,  9'h018, 2'b00, 1, 0, 16'd0, 0);
    cyc(0, 0, 0, 9'h000, 32'h0,         1,  9'h01C, 2'b00, 1, 0, 16'd0, 0);
    // granted branch redirect at pc=0x020 to 0x080
    cyc(0, 1, 0, 9'h080, 32'h0,         1,  9'h020, 2'b01, 1, 0, 16'd0, 0);
    cyc(0, 0, 0, 9'h000, 32'h0,         1,  9'h080, 2'b00, 0, 1, 16'd1, 0);
    // JALR redirect under stall with no grant for three cycles
    cyc(1, 1, 1, 9'h000, 32'hDEAD0106,  0,  9'h084, 2'b11, 1, 0, 16'd1, 0);
    cyc(1, 0, 0, 9'h000, 32'h0,         0,  9'h084, 2'b00, 0, 1, 16'd1, 1);
    cyc(1, 0, 0, 9'h000, 32'h0,         0,  9'h084, 2'b00, 0, 0, 16'd1, 1);
    cyc(1, 0, 0, 9'h000, 32'h0,         1,  9'h084, 2'b00, 0, 0, 16'd1, 1);
    cyc(0, 0, 0, 9'h000, 32'h0,         1,  9'h104, 2'b00, 0, 0, 16'd2, 0);
    // redirect to 0x1FC, then wrap to 0x000
    cyc(0, 1, 0, 9'h1FC, 32'h0,         1,  9'h108, 2'b01, 1, 0, 16'd2, 0);
    cyc(0, 0, 0, 9'h000, 32'h0,         1,  9'h1FC, 2'b00, 0, 1, 16'd3, 0);
    cyc(0, 0, 0, 9'h000, 32'h0,         1,  9'h000, 2'b00, 1, 0, 16'd3, 0);
    // back-to-back redirects, newest pending target wins
    cyc(0, 1, 0, 9'h040, 32'h0,         0,  9'h004, 2'b01, 1, 0, 16'd3, 0);
    cyc(0, 1, 0, 9'h060, 32'h0,         0,  9'h004, 2'b00, 0, 1, 16'd3, 1);
    cyc(0, 0, 0, 9'h000, 32'h0,         1,  9'h004, 2'b00, 0, 1, 16'd3, 1);
    // misaligned branch target 0x0A2 lands on 0x0A0
    cyc(0, 1, 0, 9'h0A2, 32'h0,         1,  9'h060, 2'b01, 0, 0, 16'd4, 0);
`ifdef FETCH_MISALIGN_CHECK_EN
    exp_mis = 1'b1;
`endif
    cyc(0, 0, 0, 9'h000, 32'h0,         1,  9'h0A0, 2'b00, 0, 1, 16'd5, 0);
    cyc(0, 0, 0, 9'h000, 32'h0,         1,  9'h0A4, 2'b00, 1, 0, 16'd5, 0);
    // reset while a redirect is pending
    cyc(0, 1, 0, 9'h100, 32'h0,         0,  9'h0A8, 2'b01, 1, 0, 16'd5, 0);
    cyc(0, 0, 0, 9'h000, 32'h0,         0,  9'h0A8, 2'b00, 0, 1, 16'd5, 1);
    do_reset();
    cyc(0, 0, 0, 9'h000, 32'h0,         1,  9'h000, 2'b00, 0, 0, 16'd0, 0);
    cyc(0, 0, 0, 9'h000, 32'h0,         1,  9'h004, 2'b00, 1, 0, 16'd0, 0);

    // drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_mis++;
      $display("FAIL drain: %0d expected vectors left, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
